// File: rtl/uart_bus_pkg.sv
// rtl/uart_bus_pkg.sv - shared FSM encoding, UART register map and counter helper for uart_bus_master
package uart_bus_pkg;

  // Width of the shared phase down-counter and of the phase-length parameters
  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } bus_state_e;

  // UART core register map
  typedef enum logic [3:0] {
    UART_REG_STATUS  = 4'h0,
    UART_REG_TX_DATA = 4'h1,
    UART_REG_RX_DATA = 4'h2,
    UART_REG_CTRL    = 4'h3
  } uart_reg_e;

  // Counter reload for a phase of n cycles; a length of 0 behaves as 1
  function automatic cnt_t phase_reload(input cnt_t n);
    return (n == '0) ? '0 : cnt_t'(n - cnt_t'(1));
  endfunction

endpackage

// File: rtl/uart_bus_sync2.sv
// rtl/uart_bus_sync2.sv - two-flop synchronizer with asynchronous active-low reset
module uart_bus_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - host command to UART register-bus cycle initiator; optional IRQ status poll under UART_BUS_IRQ_POLL_EN
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter logic [CNT_W-1:0] SETUP_CYC   = 4'd1,
  parameter logic [CNT_W-1:0] STROBE_CYC  = 4'd2,
  parameter logic [CNT_W-1:0] HOLD_CYC    = 4'd1,
  parameter logic [3:0]       STATUS_ADDR = 4'(UART_REG_STATUS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_write_i,
  input  logic [3:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       busy_o,
  output logic [3:0] AddrBus_o,
  output logic       n_ChipSelect_o,
  output logic       n_rd_o,
  output logic       n_we_o,
  output logic [7:0] DataBus_o,
  input  logic [7:0] DataBus_i,
  input  logic       p_IrqSig_i,
  output logic       irq_o
`ifdef UART_BUS_IRQ_POLL_EN
  ,
  output logic       irq_status_valid_o,
  output logic [7:0] irq_status_o
`endif
);

  localparam cnt_t SETUP_LD  = phase_reload(SETUP_CYC);
  localparam cnt_t STROBE_LD = phase_reload(STROBE_CYC);
  localparam cnt_t HOLD_LD   = phase_reload(HOLD_CYC);

  bus_state_e r_state;
  bus_state_e w_next;
  cnt_t       r_cnt;
  logic       r_write;
  logic [3:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rd_cap;
  logic [7:0] r_rdata;
  logic       w_cnt_zero;
  logic       w_start;
  logic       w_host_rd;
  logic       w_irq;

  uart_bus_sync2 u_irq_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (p_IrqSig_i),
    .o_q     (w_irq)
  );

  assign w_cnt_zero = (r_cnt == '0);

`ifdef UART_BUS_IRQ_POLL_EN
  logic       r_poll;
  logic       r_poll_pend;
  logic       r_irq_d;
  logic [7:0] r_irq_status;
  logic       w_poll_start;

  // A pending poll only launches in IDLE when the host is not asking; the host wins ties
  assign w_poll_start = (r_state == ST_IDLE) && !cmd_valid_i && r_poll_pend;
  assign w_start      = ((r_state == ST_IDLE) && cmd_valid_i) || w_poll_start;
  assign w_host_rd    = !r_write && !r_poll;

  // Remember each rising edge of the synchronized IRQ until its poll starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_d     <= 1'b0;
      r_poll_pend <= 1'b0;
    end else begin
      r_irq_d <= w_irq;
      if (w_irq && !r_irq_d) begin
        r_poll_pend <= 1'b1;
      end else if (w_poll_start) begin
        r_poll_pend <= 1'b0;
      end
    end
  end

  assign irq_status_o = r_irq_status;
`else
  assign w_start   = (r_state == ST_IDLE) && cmd_valid_i;
  assign w_host_rd = !r_write;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: each timed phase advances when the shared counter reaches zero
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start)    w_next = ST_SETUP;
      ST_SETUP:  if (w_cnt_zero) w_next = ST_STROBE;
      ST_STROBE: if (w_cnt_zero) w_next = ST_HOLD;
      ST_HOLD:   if (w_cnt_zero) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Command latch, phase counter reloads and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_addr   <= 4'h0;
      r_wdata  <= 8'h00;
      r_rd_cap <= 8'h00;
      r_rdata  <= 8'h00;
`ifdef UART_BUS_IRQ_POLL_EN
      r_poll       <= 1'b0;
      r_irq_status <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            r_write <= cmd_write_i;
            r_addr  <= cmd_addr_i;
            r_wdata <= cmd_wdata_i;
            r_cnt   <= SETUP_LD;
`ifdef UART_BUS_IRQ_POLL_EN
            r_poll  <= 1'b0;
          end else if (r_poll_pend) begin
            r_write <= 1'b0;
            r_addr  <= STATUS_ADDR;
            r_cnt   <= SETUP_LD;
            r_poll  <= 1'b1;
`endif
          end
        end
        ST_SETUP: begin
          r_cnt <= w_cnt_zero ? STROBE_LD : cnt_t'(r_cnt - cnt_t'(1));
        end
        ST_STROBE: begin
          if (w_cnt_zero) begin
            r_cnt <= HOLD_LD;
            if (!r_write) r_rd_cap <= DataBus_i;
          end else begin
            r_cnt <= cnt_t'(r_cnt - cnt_t'(1));
          end
        end
        ST_HOLD: begin
          if (w_cnt_zero) begin
            // Publish captured data as DONE begins so rsp_rdata_o changes with the pulse
            if (w_host_rd) r_rdata <= r_rd_cap;
`ifdef UART_BUS_IRQ_POLL_EN
            if (r_poll) r_irq_status <= r_rd_cap;
`endif
          end else begin
            r_cnt <= cnt_t'(r_cnt - cnt_t'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so an async reset releases every strobe immediately
  always_comb begin
    cmd_ready_o    = 1'b0;
    busy_o         = 1'b1;
    n_ChipSelect_o = 1'b1;
    n_rd_o         = 1'b1;
    n_we_o         = 1'b1;
    rsp_valid_o    = 1'b0;
`ifdef UART_BUS_IRQ_POLL_EN
    irq_status_valid_o = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ST_SETUP: n_ChipSelect_o = 1'b0;
      ST_STROBE: begin
        n_ChipSelect_o = 1'b0;
        n_rd_o         = r_write;
        n_we_o         = !r_write;
      end
      ST_HOLD: n_ChipSelect_o = 1'b0;
      ST_DONE: begin
`ifdef UART_BUS_IRQ_POLL_EN
        rsp_valid_o        = !r_poll;
        irq_status_valid_o = r_poll;
`else
        rsp_valid_o = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign AddrBus_o   = r_addr;
  assign DataBus_o   = r_wdata;
  assign rsp_rdata_o = r_rdata;
  assign irq_o       = w_irq;

endmodule
